// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: funct encodings, ALU op codes and the decode record.
package alu_pkg;

   localparam int ALU_XLEN = 64;
   localparam int CNT_W    = 3;

   localparam logic [3:0] F_ADD = 4'd0;
   localparam logic [3:0] F_SUB = 4'd1;
   localparam logic [3:0] F_AND = 4'd2;
   localparam logic [3:0] F_OR  = 4'd3;
   localparam logic [3:0] F_XOR = 4'd4;
   localparam logic [3:0] F_SLL = 4'd5;
   localparam logic [3:0] F_SRL = 4'd6;
   localparam logic [3:0] F_MUL = 4'd7;
   localparam logic [3:0] F_BEQ = 4'd8;
   localparam logic [3:0] F_BNE = 4'd9;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b111;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       is_mul;
      logic       is_beq;
      logic       is_bne;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational funct decode into ALU op code and op-class flags.
module alu_issue_ctrl_decode
   import alu_pkg::*;
(
   input  logic [3:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      unique case (funct)
         F_ADD: dec.alu_op = ALU_ADD;
         F_SUB: dec.alu_op = ALU_SUB;
         F_AND: dec.alu_op = ALU_AND;
         F_OR:  dec.alu_op = ALU_OR;
         F_XOR: dec.alu_op = ALU_XOR;
         F_SLL: dec.alu_op = ALU_SLL;
         F_SRL: dec.alu_op = ALU_SRL;
         F_MUL: begin
            dec.alu_op = ALU_MUL;
            dec.is_mul = 1'b1;
         end
         // Branch compares are a subtraction; only the zero flag matters.
         F_BEQ: begin
            dec.alu_op = ALU_SUB;
            dec.is_beq = 1'b1;
         end
         F_BNE: begin
            dec.alu_op = ALU_SUB;
            dec.is_bne = 1'b1;
         end
         default: begin
            dec.alu_op  = ALU_ADD;
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue controller: S1 drives registered operands into the ALU, S2 holds the result
// for writeback. MUL may hold S1 for several cycles as a multicycle path.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN        = ALU_XLEN,
   parameter int RD_W        = 5,
   parameter int MUL_LATENCY = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_funct,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_use_imm,
   input  logic [RD_W-1:0] in_rd,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_op,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [RD_W-1:0] wb_rd,
   output logic            wb_zero,
   output logic            wb_taken,
   output logic            wb_illegal
);

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);

   dec_t             dec;
   logic             vld_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic [RD_W-1:0]  rd_p1;
   logic             beq_p1;
   logic             bne_p1;
   logic             ill_p1;
   logic             vld_p2;
   logic             s1_done;
   logic             s1_adv;
   logic             accept;
   logic             taken;

   alu_issue_ctrl_decode u_decode (
      .funct (in_funct),
      .dec   (dec)
   );

   assign s1_done  = vld_p1 && (cnt_p1 == '0);
   assign s1_adv   = s1_done && (!vld_p2 || wb_ready);
   assign in_ready = rst_n && !flush && (!vld_p1 || s1_adv);
   assign accept   = in_valid && in_ready;
   assign taken    = beq_p1 ? alu_zero : (bne_p1 ? !alu_zero : 1'b0);
   assign wb_valid = vld_p2;

   // ---- S1: ALU operand drive; operands only change on a fresh accept ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         cnt_p1 <= '0;
         rd_p1  <= '0;
         beq_p1 <= 1'b0;
         bne_p1 <= 1'b0;
         ill_p1 <= 1'b0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= ALU_ADD;
      end else if (flush) begin
         vld_p1 <= 1'b0;
         cnt_p1 <= '0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         cnt_p1 <= dec.is_mul ? MUL_CNT : '0;
         rd_p1  <= in_rd;
         beq_p1 <= dec.is_beq;
         bne_p1 <= dec.is_bne;
         ill_p1 <= dec.illegal;
         alu_a  <= in_rs1;
         alu_b  <= in_use_imm ? in_imm : in_rs2;
         alu_op <= dec.alu_op;
      end else if (s1_adv) begin
         vld_p1 <= 1'b0;
      end else if (vld_p1 && (cnt_p1 != '0)) begin
         cnt_p1 <= cnt_p1 - 1'b1;
      end
   end

   // ---- S2: result hold for writeback ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2     <= 1'b0;
         wb_data    <= '0;
         wb_rd      <= '0;
         wb_zero    <= 1'b0;
         wb_taken   <= 1'b0;
         wb_illegal <= 1'b0;
      end else if (flush) begin
         vld_p2 <= 1'b0;
      end else if (s1_adv) begin
         vld_p2     <= 1'b1;
         wb_data    <= ill_p1 ? '0 : alu_result;
         wb_rd      <= rd_p1;
         wb_zero    <= ill_p1 ? 1'b0 : alu_zero;
         wb_taken   <= taken;
         wb_illegal <= ill_p1;
      end else if (wb_ready) begin
         vld_p2 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop (MUL_LATENCY=3).
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int XLEN = 64;
   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_funct;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic [RD_W-1:0] in_rd;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [2:0]      alu_op;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic            wb_valid;
   logic            wb_ready;
   logic [XLEN-1:0] wb_data;
   logic [RD_W-1:0] wb_rd;
   logic            wb_zero;
   logic            wb_taken;
   logic            wb_illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W), .MUL_LATENCY(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_zero(wb_zero), .wb_taken(wb_taken), .wb_illegal(wb_illegal)
   );

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_XOR: alu_result = alu_a ^ alu_b;
         ALU_SLL: alu_result = alu_a << alu_b[5:0];
         ALU_SRL: alu_result = alu_a >> alu_b[5:0];
         default: alu_result = alu_a * alu_b;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   typedef struct {
      string           nm;
      logic [3:0]      funct;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] imm;
      logic            use_imm;
      logic [RD_W-1:0] rd;
      logic [2:0]      e_op;
      logic [XLEN-1:0] e_b;
      logic [XLEN-1:0] e_data;
      logic            e_zero;
      logic            e_taken;
      logic            e_ill;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] imm, input logic ui, input logic [RD_W-1:0] rd);
      in_funct = f; in_rs1 = a; in_rs2 = b; in_imm = imm; in_use_imm = ui; in_rd = rd;
      in_valid = 1'b1;
   endtask

   // Called right after a negedge with in_valid high; returns at the accepting posedge.
   task automatic wait_accept(input string nm);
      int n = 0;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL %s: in_ready timeout got 0 expected 1", nm);
      end
      @(posedge clk);
   endtask

   initial begin
      logic [XLEN-1:0] hold;
      int acc;
      logic ok;

      vecs[0]  = '{"add",   F_ADD, 64'd5,      64'd7,      64'd0, 1'b0, 5'd3,  ALU_ADD, 64'd7,      64'd12,   1'b0, 1'b0, 1'b0};
      vecs[1]  = '{"sub",   F_SUB, 64'd9,      64'd9,      64'd0, 1'b0, 5'd4,  ALU_SUB, 64'd9,      64'd0,    1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"beq",   F_BEQ, 64'd3,      64'd3,      64'd0, 1'b0, 5'd5,  ALU_SUB, 64'd3,      64'd0,    1'b1, 1'b1, 1'b0};
      vecs[3]  = '{"bne_eq",F_BNE, 64'd3,      64'd3,      64'd0, 1'b0, 5'd6,  ALU_SUB, 64'd3,      64'd0,    1'b1, 1'b0, 1'b0};
      vecs[4]  = '{"bne_ne",F_BNE, 64'd3,      64'd4,      64'd0, 1'b0, 5'd8,  ALU_SUB, 64'd4,      '1,       1'b0, 1'b1, 1'b0};
      vecs[5]  = '{"imm",   F_ADD, 64'd1,      64'd99,     '1,    1'b1, 5'd9,  ALU_ADD, '1,         64'd0,    1'b1, 1'b0, 1'b0};
      vecs[6]  = '{"illeg", 4'hC,  64'd5,      64'd5,      64'd0, 1'b0, 5'd7,  ALU_ADD, 64'd5,      64'd0,    1'b0, 1'b0, 1'b1};
      vecs[7]  = '{"and",   F_AND, 64'hff0f,   64'h0ff0,   64'd0, 1'b0, 5'd10, ALU_AND, 64'h0ff0,   64'h0f00, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"or",    F_OR,  64'hf0,     64'h0f,     64'd0, 1'b0, 5'd11, ALU_OR,  64'h0f,     64'hff,   1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"xor",   F_XOR, 64'hff,     64'h0f,     64'd0, 1'b0, 5'd12, ALU_XOR, 64'h0f,     64'hf0,   1'b0, 1'b0, 1'b0};
      vecs[10] = '{"sll",   F_SLL, 64'd1,      64'h104,    64'd0, 1'b0, 5'd13, ALU_SLL, 64'h104,    64'd16,   1'b0, 1'b0, 1'b0};
      vecs[11] = '{"srl",   F_SRL, 64'h100,    64'd8,      64'd0, 1'b0, 5'd14, ALU_SRL, 64'd8,      64'd1,    1'b0, 1'b0, 1'b0};
      vecs[12] = '{"top",   F_ADD, '1,         64'd1,      64'd0, 1'b0, 5'd31, ALU_ADD, 64'd1,      64'd0,    1'b1, 1'b0, 1'b0};

      rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
      drive(F_ADD, 64'd1, 64'd1, 64'd0, 1'b0, 5'd1);
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_wb_data", wb_data, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].funct, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].use_imm, vecs[i].rd);
         wait_accept(vecs[i].nm);
         @(negedge clk);
         in_valid = 1'b0;
         chk({vecs[i].nm, "_alu_a"}, alu_a, vecs[i].rs1);
         chk({vecs[i].nm, "_alu_b"}, alu_b, vecs[i].e_b);
         chk({vecs[i].nm, "_alu_op"}, alu_op, vecs[i].e_op);
         chk({vecs[i].nm, "_wbv_early"}, wb_valid, 0);
         @(negedge clk);
         chk({vecs[i].nm, "_wb_valid"}, wb_valid, 1);
         chk({vecs[i].nm, "_wb_data"}, wb_data, vecs[i].e_data);
         chk({vecs[i].nm, "_wb_rd"}, wb_rd, vecs[i].rd);
         chk({vecs[i].nm, "_wb_zero"}, wb_zero, vecs[i].e_zero);
         chk({vecs[i].nm, "_wb_taken"}, wb_taken, vecs[i].e_taken);
         chk({vecs[i].nm, "_wb_ill"}, wb_illegal, vecs[i].e_ill);
      end

      // MUL held three cycles, following ADD accepted on the cycle MUL leaves S1
      @(negedge clk);
      drive(F_MUL, 64'd6, 64'd7, 64'd0, 1'b0, 5'd2);
      wait_accept("mul");
      @(negedge clk);
      drive(F_ADD, 64'd1, 64'd1, 64'd0, 1'b0, 5'd3);
      #1;
      chk("mul_rdy_c1", in_ready, 0);
      chk("mul_op_c1", alu_op, ALU_MUL);
      chk("mul_a_c1", alu_a, 64'd6);
      @(negedge clk); #1;
      chk("mul_rdy_c2", in_ready, 0);
      chk("mul_b_c2", alu_b, 64'd7);
      @(negedge clk); #1;
      chk("mul_rdy_c3", in_ready, 1);
      chk("mul_a_c3", alu_a, 64'd6);
      chk("mul_wbv_c3", wb_valid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mul_wbv", wb_valid, 1);
      chk("mul_data", wb_data, 64'd42);
      chk("mul_rd", wb_rd, 2);
      chk("add_after_op", alu_op, ALU_ADD);
      @(negedge clk);
      chk("add_after_v", wb_valid, 1);
      chk("add_after_data", wb_data, 64'd2);
      @(negedge clk);
      chk("add_after_drain", wb_valid, 0);

      // Writeback stall: only two ops fit, result held stable
      wb_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(F_ADD, 64'(10 + acc), 64'd0, 64'd0, 1'b0, RD_W'(acc));
         if (c >= 2) begin
            chk("stall_wbv", wb_valid, 1);
            chk("stall_data", wb_data, 64'd10);
         end
         #1;
         ok = in_ready;
         @(posedge clk);
         if (ok) acc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("stall_acc", 64'(acc), 64'd2);
      chk("stall_rdy", in_ready, 0);
      chk("stall_rd", wb_rd, 0);
      wb_ready = 1'b1;
      chk("rel0_data", wb_data, 64'd10);
      @(negedge clk);
      chk("rel1_v", wb_valid, 1);
      chk("rel1_data", wb_data, 64'd11);
      chk("rel1_rd", wb_rd, 1);
      @(negedge clk);
      chk("rel_drain", wb_valid, 0);

      // Flush while MUL has one count left
      hold = wb_data;
      drive(F_MUL, 64'd6, 64'd7, 64'd0, 1'b0, 5'd4);
      wait_accept("fl_mul");
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      drive(F_ADD, 64'd3, 64'd3, 64'd0, 1'b0, 5'd5);
      #1;
      chk("fl_rdy_during", in_ready, 0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("fl_wbv", wb_valid, 0);
      chk("fl_rdy", in_ready, 1);
      chk("fl_alu_a", alu_a, 64'd6);
      chk("fl_wb_data", wb_data, hold);
      repeat (4) @(negedge clk);
      chk("fl_no_wb", wb_valid, 0);

      // Async reset with an op in S1
      drive(F_ADD, 64'd5, 64'd7, 64'd0, 1'b0, 5'd6);
      wait_accept("rst_mid");
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstm_alu_a", alu_a, 0);
      chk("rstm_alu_b", alu_b, 0);
      chk("rstm_rdy", in_ready, 0);
      chk("rstm_wb_data", wb_data, 0);
      chk("rstm_wbv", wb_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstm_after", wb_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
